stack_frame_register: RTL and testbench

Parametrised hardware stack with integrated stack-pointer and base-pointer registers, the successor to the fixed 16-bit stack-pointer and base-pointer registers in the special-purpose register set. It holds `DEPTH` words of `WIDTH` bits internally. It supports push, pop, and direct pointer loads, plus two-cycle ENTER/LEAVE frame operations. Overflow and underflow are detected and reported through a sticky error flag. It sits beside the general register file and is driven by the control unit's stack-op field.

---
 rtl/stack_frame_register.sv | 164 ++++++++++++++++
 tb/tb_stack_frame_register.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/stack_frame_register.sv
//------------------------------------------------------------------------------
// Module      : stack_frame_register
// Description : Parametrised hardware stack with stack-pointer and
//               base-pointer registers, single-cycle push/pop/pointer loads,
//               two-cycle ENTER/LEAVE frame operations and a sticky error flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stack_frame_register #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           writeData,
    output logic [WIDTH-1:0]           data,
    output logic [$clog2(DEPTH):0]     stackPointer,
    output logic [$clog2(DEPTH):0]     basePointer,
    output logic                       full,
    output logic                       empty,
    output logic                       busy,
    output logic                       error
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] c_OP_NOP    = 3'd0;
    localparam logic [2:0] c_OP_PUSH   = 3'd1;
    localparam logic [2:0] c_OP_POP    = 3'd2;
    localparam logic [2:0] c_OP_LOADSP = 3'd3;
    localparam logic [2:0] c_OP_LOADBP = 3'd4;
    localparam logic [2:0] c_OP_ENTER  = 3'd5;
    localparam logic [2:0] c_OP_LEAVE  = 3'd6;
    localparam logic [2:0] c_OP_CLRERR = 3'd7;

    localparam logic [AW:0] c_ONE   = (AW+1)'(1);
    localparam logic [AW:0] c_ZERO  = '0;
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTER2 = 2'd1,
        S_LEAVE2 = 2'd2
    } state_t;

    state_t             r_state;
    logic [AW:0]        r_sp;
    logic [AW:0]        r_bp;
    logic               r_err;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_full;
    logic               w_empty;
    logic               w_idle;
    logic [AW:0]        w_sp_m1;
    logic [AW-1:0]      w_top_idx;
    logic [WIDTH-1:0]   w_top_word;
    logic [AW:0]        w_wd_ptr;
    logic               w_wd_ok;
    logic               w_mem_we;
    logic [WIDTH-1:0]   w_mem_wdata;

    // Pointer decode and top-of-stack read (index SP-1, valid only when not empty)
    always_comb begin
        w_full      = (r_sp == c_DEPTH);
        w_empty     = (r_sp == c_ZERO);
        w_idle      = (r_state == S_IDLE);
        w_sp_m1     = r_sp - c_ONE;
        w_top_idx   = w_sp_m1[AW-1:0];
        w_top_word  = r_mem[w_top_idx];
        w_wd_ptr    = writeData[AW:0];
        w_wd_ok     = (w_wd_ptr <= c_DEPTH);
        // Both PUSH and ENTER cycle 1 store one word at mem[SP] when not full
        w_mem_we    = w_idle && !w_full && ((op == c_OP_PUSH) || (op == c_OP_ENTER));
        w_mem_wdata = (op == c_OP_ENTER) ? WIDTH'(r_bp) : writeData;
    end

    // Stack storage: deliberately not reset; stale words are hidden by the empty check
    always_ff @(posedge clock) begin
        if (reset && w_mem_we) begin
            r_mem[r_sp[AW-1:0]] <= w_mem_wdata;
        end
    end

    // Control FSM, pointer registers and sticky error flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_sp    <= c_ZERO;
            r_bp    <= c_ZERO;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_ENTER2: begin
                    // SP already points just above the saved BP slot
                    r_bp    <= r_sp;
                    r_state <= S_IDLE;
                end
                S_LEAVE2: begin
                    // SP == old BP (non-zero), so mem[SP-1] holds the saved BP
                    r_bp    <= w_top_word[AW:0];
                    r_sp    <= w_sp_m1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    case (op)
                        c_OP_PUSH: begin
                            if (w_full) r_err <= 1'b1;
                            else        r_sp  <= r_sp + c_ONE;
                        end
                        c_OP_POP: begin
                            if (w_empty) r_err <= 1'b1;
                            else         r_sp  <= w_sp_m1;
                        end
                        c_OP_LOADSP: begin
                            if (w_wd_ok) r_sp  <= w_wd_ptr;
                            else         r_err <= 1'b1;
                        end
                        c_OP_LOADBP: begin
                            if (w_wd_ok) r_bp  <= w_wd_ptr;
                            else         r_err <= 1'b1;
                        end
                        c_OP_ENTER: begin
                            if (w_full) begin
                                r_err <= 1'b1;
                            end else begin
                                r_sp    <= r_sp + c_ONE;
                                r_state <= S_ENTER2;
                            end
                        end
                        c_OP_LEAVE: begin
                            if (r_bp == c_ZERO) begin
                                r_err <= 1'b1;
                            end else begin
                                r_sp    <= r_bp;
                                r_state <= S_LEAVE2;
                            end
                        end
                        c_OP_CLRERR: r_err <= 1'b0;
                        c_OP_NOP:    ;
                        default:     ;
                    endcase
                end
            endcase
        end
    end

    // Output decode from registered state
    always_comb begin
        data         = w_empty ? '0 : w_top_word;
        stackPointer = r_sp;
        basePointer  = r_bp;
        full         = w_full;
        empty        = w_empty;
        busy         = !w_idle;
        error        = r_err;
    end

endmodule

`default_nettype wire

// File: tb/tb_stack_frame_register.sv
//------------------------------------------------------------------------------
// Module      : tb_stack_frame_register
// Description : Directed self-checking bench for stack_frame_register
//               (WIDTH = 16, DEPTH = 4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stack_frame_register;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    localparam logic [2:0] NOP    = 3'd0;
    localparam logic [2:0] PUSH   = 3'd1;
    localparam logic [2:0] POP    = 3'd2;
    localparam logic [2:0] LOADSP = 3'd3;
    localparam logic [2:0] LOADBP = 3'd4;
    localparam logic [2:0] ENTER  = 3'd5;
    localparam logic [2:0] LEAVE  = 3'd6;
    localparam logic [2:0] CLRERR = 3'd7;

    logic             clock;
    logic             reset;
    logic [2:0]       op;
    logic [WIDTH-1:0] writeData;
    logic [WIDTH-1:0] data;
    logic [2:0]       stackPointer;
    logic [2:0]       basePointer;
    logic             full;
    logic             empty;
    logic             busy;
    logic             error;

    int tests = 0;
    int fails = 0;

    stack_frame_register #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .op           (op),
        .writeData    (writeData),
        .data         (data),
        .stackPointer (stackPointer),
        .basePointer  (basePointer),
        .full         (full),
        .empty        (empty),
        .busy         (busy),
        .error        (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply one op for one clock edge, then sample 1 ns after that edge
    task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] d);
        op        = o;
        writeData = d;
        @(posedge clock);
        #1;
        op        = NOP;
        writeData = '0;
    endtask

    task automatic apply_reset();
        op        = NOP;
        writeData = '0;
        reset     = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset     = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (stackPointer !== 3'd0) begin fails++; $display("FAIL reset_sp: got %0d expected 0", stackPointer); end
        tests++; if (basePointer !== 3'd0) begin fails++; $display("FAIL reset_bp: got %0d expected 0", basePointer); end
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", error); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL reset_flags: got empty=%b full=%b expected empty=1 full=0", empty, full); end
        tests++; if (data !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h expected 0000", data); end
    endtask

    task automatic test_push_pop();
        apply_reset();
        do_op(PUSH, 16'h1111);
        tests++; if (stackPointer !== 3'd1 || data !== 16'h1111) begin fails++; $display("FAIL push1: got sp=%0d data=%h expected sp=1 data=1111", stackPointer, data); end
        do_op(PUSH, 16'h2222);
        tests++; if (stackPointer !== 3'd2 || data !== 16'h2222) begin fails++; $display("FAIL push2: got sp=%0d data=%h expected sp=2 data=2222", stackPointer, data); end
        do_op(POP, 16'h0000);
        tests++; if (stackPointer !== 3'd1 || data !== 16'h1111 || empty !== 1'b0) begin fails++; $display("FAIL pop1: got sp=%0d data=%h empty=%b expected sp=1 data=1111 empty=0", stackPointer, data, empty); end
    endtask

    task automatic test_overflow();
        apply_reset();
        do_op(PUSH, 16'hA001);
        do_op(PUSH, 16'hA002);
        do_op(PUSH, 16'hA003);
        do_op(PUSH, 16'hA004);
        tests++; if (stackPointer !== 3'd4 || full !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL fill: got sp=%0d full=%b err=%b expected sp=4 full=1 err=0", stackPointer, full, error); end
        do_op(PUSH, 16'hBEEF);
        tests++; if (stackPointer !== 3'd4 || full !== 1'b1 || error !== 1'b1 || data !== 16'hA004) begin fails++; $display("FAIL overflow: got sp=%0d full=%b err=%b data=%h expected sp=4 full=1 err=1 data=a004", stackPointer, full, error, data); end
        do_op(CLRERR, 16'h0000);
        tests++; if (error !== 1'b0 || stackPointer !== 3'd4 || data !== 16'hA004) begin fails++; $display("FAIL clrerr: got err=%b sp=%0d data=%h expected err=0 sp=4 data=a004", error, stackPointer, data); end
        do_op(ENTER, 16'h0000);
        tests++; if (error !== 1'b1 || busy !== 1'b0 || stackPointer !== 3'd4) begin fails++; $display("FAIL enter_full: got err=%b busy=%b sp=%0d expected err=1 busy=0 sp=4", error, busy, stackPointer); end
    endtask

    task automatic test_underflow_and_load();
        apply_reset();
        do_op(POP, 16'h0000);
        tests++; if (error !== 1'b1 || stackPointer !== 3'd0 || data !== 16'h0000) begin fails++; $display("FAIL underflow: got err=%b sp=%0d data=%h expected err=1 sp=0 data=0000", error, stackPointer, data); end
        do_op(LOADSP, 16'h0005);
        tests++; if (stackPointer !== 3'd0 || error !== 1'b1) begin fails++; $display("FAIL loadsp_range: got sp=%0d err=%b expected sp=0 err=1", stackPointer, error); end
        do_op(CLRERR, 16'h0000);
        do_op(LOADBP, 16'h0007);
        tests++; if (basePointer !== 3'd0 || error !== 1'b1) begin fails++; $display("FAIL loadbp_range: got bp=%0d err=%b expected bp=0 err=1", basePointer, error); end
        do_op(LOADBP, 16'hFFF4);
        tests++; if (basePointer !== 3'd4) begin fails++; $display("FAIL loadbp_max: got bp=%0d expected 4", basePointer); end
        do_op(LOADSP, 16'h0002);
        tests++; if (stackPointer !== 3'd2 || empty !== 1'b0) begin fails++; $display("FAIL loadsp_ok: got sp=%0d empty=%b expected sp=2 empty=0", stackPointer, empty); end
    endtask

    task automatic test_enter_leave();
        apply_reset();
        do_op(LOADBP, 16'h0000);
        do_op(PUSH, 16'h0010);
        do_op(PUSH, 16'h0020);
        do_op(ENTER, 16'h0000);
        tests++; if (stackPointer !== 3'd3 || busy !== 1'b1 || basePointer !== 3'd0 || data !== 16'h0000) begin fails++; $display("FAIL enter_c1: got sp=%0d busy=%b bp=%0d data=%h expected sp=3 busy=1 bp=0 data=0000", stackPointer, busy, basePointer, data); end
        do_op(NOP, 16'h0000);
        tests++; if (basePointer !== 3'd3 || busy !== 1'b0 || stackPointer !== 3'd3) begin fails++; $display("FAIL enter_c2: got bp=%0d busy=%b sp=%0d expected bp=3 busy=0 sp=3", basePointer, busy, stackPointer); end
        do_op(PUSH, 16'h0030);
        tests++; if (stackPointer !== 3'd4 || data !== 16'h0030) begin fails++; $display("FAIL frame_push: got sp=%0d data=%h expected sp=4 data=0030", stackPointer, data); end
        do_op(LEAVE, 16'h0000);
        tests++; if (stackPointer !== 3'd3 || busy !== 1'b1 || basePointer !== 3'd3) begin fails++; $display("FAIL leave_c1: got sp=%0d busy=%b bp=%0d expected sp=3 busy=1 bp=3", stackPointer, busy, basePointer); end
        do_op(NOP, 16'h0000);
        tests++; if (stackPointer !== 3'd2 || basePointer !== 3'd0 || busy !== 1'b0 || data !== 16'h0020) begin fails++; $display("FAIL leave_c2: got sp=%0d bp=%0d busy=%b data=%h expected sp=2 bp=0 busy=0 data=0020", stackPointer, basePointer, busy, data); end
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL frame_err: got %b expected 0", error); end
    endtask

    task automatic test_busy_ignore();
        apply_reset();
        do_op(PUSH, 16'h0010);
        do_op(PUSH, 16'h0020);
        do_op(LOADBP, 16'h0002);
        do_op(ENTER, 16'h0000);
        tests++; if (stackPointer !== 3'd3 || data !== 16'h0002) begin fails++; $display("FAIL enter_savebp: got sp=%0d data=%h expected sp=3 data=0002", stackPointer, data); end
        do_op(PUSH, 16'h0099);
        tests++; if (stackPointer !== 3'd3 || basePointer !== 3'd3 || busy !== 1'b0 || data !== 16'h0002) begin fails++; $display("FAIL busy_push: got sp=%0d bp=%0d busy=%b data=%h expected sp=3 bp=3 busy=0 data=0002", stackPointer, basePointer, busy, data); end
        do_op(LEAVE, 16'h0000);
        do_op(NOP, 16'h0000);
        tests++; if (stackPointer !== 3'd2 || basePointer !== 3'd2 || data !== 16'h0020) begin fails++; $display("FAIL leave_restore: got sp=%0d bp=%0d data=%h expected sp=2 bp=2 data=0020", stackPointer, basePointer, data); end
        // CLRERR arriving during the second ENTER cycle must be dropped
        do_op(POP, 16'h0000);
        do_op(POP, 16'h0000);
        do_op(POP, 16'h0000);
        tests++; if (error !== 1'b1 || stackPointer !== 3'd0) begin fails++; $display("FAIL pop_to_fault: got err=%b sp=%0d expected err=1 sp=0", error, stackPointer); end
        do_op(ENTER, 16'h0000);
        do_op(CLRERR, 16'h0000);
        tests++; if (error !== 1'b1 || basePointer !== 3'd1 || stackPointer !== 3'd1) begin fails++; $display("FAIL busy_clrerr: got err=%b bp=%0d sp=%0d expected err=1 bp=1 sp=1", error, basePointer, stackPointer); end
        apply_reset();
        do_op(LEAVE, 16'h0000);
        tests++; if (error !== 1'b1 || stackPointer !== 3'd0 || basePointer !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL leave_bp0: got err=%b sp=%0d bp=%0d busy=%b expected err=1 sp=0 bp=0 busy=0", error, stackPointer, basePointer, busy); end
    endtask

    task automatic test_reset_mid_enter();
        apply_reset();
        do_op(POP, 16'h0000);
        do_op(PUSH, 16'h0055);
        do_op(ENTER, 16'h0000);
        tests++; if (busy !== 1'b1 || error !== 1'b1 || stackPointer !== 3'd2) begin fails++; $display("FAIL pre_abort: got busy=%b err=%b sp=%0d expected busy=1 err=1 sp=2", busy, error, stackPointer); end
        #2;
        reset = 1'b0;
        #1;
        tests++; if (stackPointer !== 3'd0 || basePointer !== 3'd0 || busy !== 1'b0 || error !== 1'b0 || data !== 16'h0000) begin fails++; $display("FAIL async_abort: got sp=%0d bp=%0d busy=%b err=%b data=%h expected all zero", stackPointer, basePointer, busy, error, data); end
        #1;
        reset = 1'b1;
        do_op(NOP, 16'h0000);
        tests++; if (basePointer !== 3'd0 || busy !== 1'b0 || empty !== 1'b1) begin fails++; $display("FAIL post_abort: got bp=%0d busy=%b empty=%b expected bp=0 busy=0 empty=1", basePointer, busy, empty); end
    endtask

    initial begin
        reset     = 1'b0;
        op        = NOP;
        writeData = '0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow_and_load();
        test_enter_leave();
        test_busy_ignore();
        test_reset_mid_enter();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
